// File: rtl/hack_rom_loader_if.sv
// hack_rom_loader_if: byte-stream input and ROM write / status outputs of the HACK ROM loader.
// master: the loader itself. slave: the byte source and ROM / CPU side.
interface hack_rom_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [14:0] rom_addr;
  logic [15:0] rom_data;
  logic        rom_load;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rom_addr,
    output rom_data,
    output rom_load,
    output cpu_rst,
    output busy,
    output done,
    output error
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rom_addr,
    input  rom_data,
    input  rom_load,
    input  cpu_rst,
    input  busy,
    input  done,
    input  error
  );
endinterface

// File: rtl/hack_rom_loader.sv
// hack_rom_loader: receives a framed HACK program from a UART byte stream and writes it into
// the instruction ROM, holding the CPU in reset while loading or after a failed load.
// Frame: HDR_BYTE, count high, count low, count words (high byte first), and, when the macro
// ROM_LOADER_CHECKSUM_EN is defined, a trailing checksum byte equal to the XOR of all data bytes.
// A frame stalls into the error state after TIMEOUT_CYCLES cycles without a byte.
module hack_rom_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter logic [7:0]  HDR_BYTE       = 8'hA5
) (
  input logic               clk,
  input logic               rst,
  hack_rom_loader_if.master bus
);

  localparam int unsigned TimerWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
    StDone,
    StError
`ifdef ROM_LOADER_CHECKSUM_EN
    , StCheck
`endif
  } state_e;

  state_e                state_q;
  logic [14:0]           count_q;
  logic [14:0]           addr_q;
  logic [7:0]            data_hi_q;
  logic [TimerWidth-1:0] timer_q;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  logic [14:0] rom_addr_q;
  logic [15:0] rom_data_q;
  logic        rom_load_q;
  logic        cpu_rst_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;

  // A frame is open in every state except the three resting states.
  logic in_frame;
  assign in_frame = (state_q != StIdle) && (state_q != StDone) && (state_q != StError);

  // Frame parser, inter-byte timer and registered ROM / status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      addr_q     <= '0;
      data_hi_q  <= '0;
      timer_q    <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
      rom_addr_q <= '0;
      rom_data_q <= '0;
      rom_load_q <= 1'b0;
      cpu_rst_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      rom_load_q <= 1'b0;
      if (!in_frame) begin
        timer_q <= '0;
        // Only a header byte opens a frame; anything else is line noise.
        if (bus.rx_valid && (bus.rx_data == HDR_BYTE)) begin
          state_q   <= StLenHi;
          busy_q    <= 1'b1;
          cpu_rst_q <= 1'b1;
          done_q    <= 1'b0;
          error_q   <= 1'b0;
        end
      end else if (timer_q == TimerLast) begin
        // Timeout wins over a byte arriving in the same cycle; that byte is dropped.
        timer_q   <= '0;
        state_q   <= StError;
        busy_q    <= 1'b0;
        error_q   <= 1'b1;
        cpu_rst_q <= 1'b1;
      end else if (!bus.rx_valid) begin
        timer_q <= timer_q + 1'b1;
      end else begin
        timer_q <= '0;
        case (state_q)
          StLenHi: begin
            // Counts above 32767 would need a 16th address bit.
            if (bus.rx_data[7]) begin
              state_q   <= StError;
              busy_q    <= 1'b0;
              error_q   <= 1'b1;
              cpu_rst_q <= 1'b1;
            end else begin
              count_q[14:8] <= bus.rx_data[6:0];
              state_q       <= StLenLo;
            end
          end
          StLenLo: begin
            count_q[7:0] <= bus.rx_data;
            addr_q       <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
            if ({count_q[14:8], bus.rx_data} == 15'd0) begin
`ifdef ROM_LOADER_CHECKSUM_EN
              state_q   <= StCheck;
`else
              state_q   <= StDone;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
`endif
            end else begin
              state_q <= StDataHi;
            end
          end
          StDataHi: begin
            data_hi_q <= bus.rx_data;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_q    <= csum_q ^ bus.rx_data;
`endif
            state_q   <= StDataLo;
          end
          StDataLo: begin
            // The write strobe lands in the cycle after the low byte; address/data then hold.
            rom_addr_q <= addr_q;
            rom_data_q <= {data_hi_q, bus.rx_data};
            rom_load_q <= 1'b1;
            addr_q     <= addr_q + 15'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ bus.rx_data;
`endif
            if (addr_q == (count_q - 15'd1)) begin
`ifdef ROM_LOADER_CHECKSUM_EN
              state_q   <= StCheck;
`else
              state_q   <= StDone;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
`endif
            end else begin
              state_q <= StDataHi;
            end
          end
`ifdef ROM_LOADER_CHECKSUM_EN
          StCheck: begin
            busy_q <= 1'b0;
            if (bus.rx_data == csum_q) begin
              state_q   <= StDone;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else begin
              state_q   <= StError;
              error_q   <= 1'b1;
              cpu_rst_q <= 1'b1;
            end
          end
`endif
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.rom_data = rom_data_q;
  assign bus.rom_load = rom_load_q;
  assign bus.cpu_rst  = cpu_rst_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;

endmodule
